i2s_audio_fifo: RTL and testbench

Parametrised successor to the NeXT sound-box audio path. It buffers decoded audio packet payloads in a FIFO and issues credit-based audio_req pulses to the OpEncoder. It serialises stereo or mono samples as I2S, with bit clock and word clock derived internally from mon_clk. It sits between OpDecoder (is_audio/audio_starts) and the DAC pins, replacing the unbuffered I2S sender.

---
 rtl/i2s_audio_fifo.sv | 157 +++++++++++++++
 tb/tb_i2s_audio_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_fifo.sv
// Buffered I2S audio sender: packet-word FIFO with credit-based audio_req,
// internally divided bit/word clocks and stereo or duplicated-mono framing.
module i2s_audio_fifo #(
  parameter int SAMPLE_W    = 16,
  parameter int DEPTH       = 8,
  parameter int BCLK_DIV    = 4,
  parameter int REQ_SPACING = 64
) (
  input  logic                       mon_clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [2*SAMPLE_W-1:0]      in_data,
  input  logic                       mono,
  input  logic                       start,
  output logic                       audio_req,
  output logic                       bclk,
  output logic                       lrck,
  output logic                       sdata,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       underrun,
  output logic                       overflow
);

  localparam int FW  = 2 * SAMPLE_W;
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int CSW = LW + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int DW  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int SW  = $clog2(FW);
  localparam int CW  = (REQ_SPACING > 1) ? $clog2(REQ_SPACING) : 1;

  typedef enum logic {PH_S0, PH_S1} phase_t;

  logic [FW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [DW-1:0]  div;
  logic [SW-1:0]  slot, slot_nx, bit_idx;
  logic [FW-1:0]  frame, frame_nx, head;
  logic [LW-1:0]  pending;
  logic [CW-1:0]  spacing;
  logic [CSW-1:0] credit_sum;
  phase_t         phase, phase_nx;
  logic           div_tc, fall, load, pop, set_underrun, wr_ok, req, mem_we;
  logic [AW-1:0]  mem_waddr;

  assign div_tc     = (div == DW'(BCLK_DIV - 1));
  assign fall       = div_tc && bclk;
  assign load       = fall && (slot == SW'(FW - 1));
  assign slot_nx    = (slot == SW'(FW - 1)) ? '0 : slot + 1'b1;
  // Slot 0 replays bit 0 of the outgoing frame (one-bit I2S delay).
  assign bit_idx    = (slot_nx == '0) ? '0 : SW'(FW - int'(slot_nx));
  assign head       = mem[rd_ptr];
  assign credit_sum = {1'b0, fifo_level} + {1'b0, pending};
  assign req        = (credit_sum < CSW'(DEPTH)) && (spacing == '0);
  assign wr_ok      = in_valid && ((fifo_level != LW'(DEPTH)) || pop);
  assign mem_we     = in_valid && (start || wr_ok);
  assign mem_waddr  = start ? '0 : wr_ptr;

  always_comb begin
    frame_nx     = frame;
    phase_nx     = phase;
    pop          = 1'b0;
    set_underrun = 1'b0;
    if (load) begin
      if (fifo_level == '0) begin
        frame_nx     = '0;
        set_underrun = 1'b1;
      end else if (!mono) begin
        frame_nx = head;
        pop      = 1'b1;
      end else if (phase == PH_S0) begin
        frame_nx = {2{head[FW-1:SAMPLE_W]}};
        phase_nx = PH_S1;
      end else begin
        frame_nx = {2{head[SAMPLE_W-1:0]}};
        phase_nx = PH_S0;
        pop      = 1'b1;
      end
    end
  end

  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n)     phase <= PH_S0;
    else if (start) phase <= PH_S0;
    else            phase <= phase_nx;
  end

  always_ff @(posedge mon_clk) begin
    if (mem_we) mem[mem_waddr] <= in_data;
  end

  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      bclk       <= 1'b0;
      slot       <= '0;
      lrck       <= 1'b0;
      sdata      <= 1'b0;
      frame      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pending    <= '0;
      spacing    <= '0;
      audio_req  <= 1'b0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else if (start) begin
      // Flush, then accept a coincident word into the emptied FIFO.
      div        <= '0;
      bclk       <= 1'b0;
      slot       <= '0;
      lrck       <= 1'b0;
      sdata      <= 1'b0;
      frame      <= '0;
      wr_ptr     <= in_valid ? AW'(1) : '0;
      rd_ptr     <= '0;
      fifo_level <= in_valid ? LW'(1) : '0;
      pending    <= '0;
      spacing    <= '0;
      audio_req  <= 1'b0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (div_tc) begin
        div  <= '0;
        bclk <= ~bclk;
      end else begin
        div <= div + 1'b1;
      end
      if (fall) begin
        slot  <= slot_nx;
        lrck  <= (slot_nx >= SW'(SAMPLE_W));
        sdata <= frame[bit_idx];
      end
      frame <= frame_nx;
      if (set_underrun) underrun <= 1'b1;
      if (in_valid && !wr_ok) overflow <= 1'b1;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
      audio_req <= req;
      case ({req, in_valid})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   if (pending != '0) pending <= pending - 1'b1;
        default: ;
      endcase
      if (req)                 spacing <= CW'(REQ_SPACING - 1);
      else if (spacing != '0)  spacing <= spacing - 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_audio_fifo.sv
// Randomised scoreboard bench for i2s_audio_fifo: a cycle-counting queue model
// predicts frames and status; a serial monitor rebuilds frames from the pins.
module tb_i2s_audio_fifo;

  localparam int SAMPLE_W    = 16;
  localparam int DEPTH       = 8;
  localparam int BCLK_DIV    = 4;
  localparam int REQ_SPACING = 64;
  localparam int FW          = 2 * SAMPLE_W;
  localparam int LW          = $clog2(DEPTH + 1);
  localparam int FRAME_CYC   = 2 * BCLK_DIV * FW;

  logic          mon_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic          mono = 1'b0;
  logic          start = 1'b0;
  logic          audio_req, bclk, lrck, sdata, underrun, overflow;
  logic [LW-1:0] fifo_level;

  i2s_audio_fifo #(
    .SAMPLE_W(SAMPLE_W),
    .DEPTH(DEPTH),
    .BCLK_DIV(BCLK_DIV),
    .REQ_SPACING(REQ_SPACING)
  ) dut (
    .mon_clk(mon_clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .mono(mono),
    .start(start),
    .audio_req(audio_req),
    .bclk(bclk),
    .lrck(lrck),
    .sdata(sdata),
    .fifo_level(fifo_level),
    .underrun(underrun),
    .overflow(overflow)
  );

  always #5 mon_clk = ~mon_clk;

  // Reference model: loads every FRAME_CYC cycles after reset/start,
  // requests gated by time since the last request and outstanding credit.
  logic [FW-1:0] m_q[$];
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] m_head, m_f;
  int            m_pending, m_last, m_e, restart_cnt = 0;
  bit            m_phase, m_under, m_over, m_req, m_now;

  always @(posedge mon_clk) begin
    if (!rst_n || start) begin
      m_q.delete();
      exp_q.delete();
      exp_q.push_back('0);
      m_pending = 0;
      m_last    = -1000000;
      m_e       = 0;
      m_phase   = 1'b0;
      m_under   = 1'b0;
      m_over    = 1'b0;
      m_req     = 1'b0;
      restart_cnt++;
      if (rst_n && in_valid) m_q.push_back(in_data);
    end else begin
      m_e++;
      m_now = (m_q.size() + m_pending < DEPTH) && (m_e - m_last >= REQ_SPACING);
      if (m_e % FRAME_CYC == 0) begin
        if (m_q.size() == 0) begin
          exp_q.push_back('0);
          m_under = 1'b1;
        end else begin
          m_head = m_q[0];
          if (!mono) begin
            m_f = m_head;
            void'(m_q.pop_front());
          end else if (!m_phase) begin
            m_f = {2{m_head[FW-1:SAMPLE_W]}};
            m_phase = 1'b1;
          end else begin
            m_f = {2{m_head[SAMPLE_W-1:0]}};
            m_phase = 1'b0;
            void'(m_q.pop_front());
          end
          exp_q.push_back(m_f);
        end
      end
      if (in_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(in_data);
        else m_over = 1'b1;
      end
      if (m_now && !in_valid) m_pending++;
      else if (!m_now && in_valid && m_pending > 0) m_pending--;
      if (m_now) m_last = m_e;
      m_req = m_now;
    end
  end

  int            checks = 0, errors = 0;
  int            mon_seen = -1, rises = 0, k_slot, frames_seen = 0;
  int            cyc = 0, pulse_cnt = 0, first_pulse = -1;
  bit            have_frame = 1'b0, prev_bclk = 1'b0, cur_mono = 1'b0;
  logic [FW-1:0] word = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs at each falling mon_clk edge: status compare plus serial frame monitor.
  task automatic sample();
    cyc++;
    if (audio_req === 1'b1) begin
      pulse_cnt++;
      if (first_pulse < 0) first_pulse = cyc;
    end
    chk("audio_req", audio_req, m_req);
    chk("fifo_level", fifo_level, m_q.size());
    chk("underrun", underrun, m_under);
    chk("overflow", overflow, m_over);
    if (mon_seen != restart_cnt) begin
      mon_seen   = restart_cnt;
      rises      = 0;
      have_frame = 1'b0;
      word       = '0;
      prev_bclk  = bclk;
    end else begin
      if (bclk && !prev_bclk) begin
        k_slot = rises % FW;
        rises++;
        chk("lrck", lrck, (k_slot >= SAMPLE_W));
        if (k_slot == 0) begin
          if (have_frame) begin
            word[0] = sdata;
            frames_seen++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_unexpected actual=%0h expected=none at %0t", word, $time);
            end else begin
              chk("frame", word, exp_q.pop_front());
            end
          end
          have_frame = 1'b1;
        end else begin
          word[FW-k_slot] = sdata;
        end
      end
      prev_bclk = bclk;
    end
  endtask

  task automatic step(input logic v, input logic [FW-1:0] d, input logic m, input logic s);
    in_valid = v;
    in_data  = d;
    mono     = m;
    start    = s;
    @(negedge mon_clk);
    sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, cur_mono, 1'b0);
  endtask

  task automatic wait_phase(input int t);
    for (int i = 0; i < FRAME_CYC + 1 && (m_e % FRAME_CYC) != t; i++) idle(1);
  endtask

  initial begin
    idle(3);
    chk("rst_bclk", bclk, 1'b0);
    chk("rst_lrck", lrck, 1'b0);
    chk("rst_sdata", sdata, 1'b0);
    chk("rst_req", audio_req, 1'b0);
    chk("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    cyc = 0;
    pulse_cnt = 0;
    first_pulse = -1;

    // Idle after reset: eight spaced requests, underrun at the first load.
    idle(600);
    chk("first_req_cycle", first_pulse, 1);
    chk("req_count", pulse_cnt, 8);
    chk("idle_underrun", underrun, 1'b1);

    // Stereo word with asymmetric halves.
    step(1'b1, 32'h8001_7FFE, 1'b0, 1'b0);
    idle(600);

    // Mono word from a clean start: two loads, no underrun until the third.
    cur_mono = 1'b1;
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h1234_ABCD, 1'b1, 1'b0);
    idle(650);
    chk("mono_no_underrun", underrun, 1'b0);
    chk("mono_drained", fifo_level, 0);
    idle(200);
    cur_mono = 1'b0;

    // Nine back-to-back writes clear of any frame load.
    wait_phase(8);
    for (int i = 0; i < 9; i++) step(1'b1, 32'hA500_0000 | i, 1'b0, 1'b0);
    chk("burst_level", fifo_level, DEPTH);
    chk("burst_overflow", overflow, 1'b1);
    idle(8 * FRAME_CYC + 300);

    // Restart in slot 20 with a coincident word.
    wait_phase(20 * 2 * BCLK_DIV + 2);
    step(1'b1, 32'h0F0F_F0F0, 1'b0, 1'b1);
    chk("start_level", fifo_level, 1);
    chk("start_underrun", underrun, 1'b0);
    chk("start_overflow", overflow, 1'b0);
    chk("start_bclk", bclk, 1'b0);
    chk("start_lrck", lrck, 1'b0);
    chk("start_sdata", sdata, 1'b0);
    chk("start_req", audio_req, 1'b0);
    idle(900);

    // Answer three outstanding credits, then let the frames drain.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    idle(1200);

    // Randomised traffic, mode changes and occasional restarts.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 399) == 0) cur_mono = ~cur_mono;
      step(($urandom_range(0, 99) == 0), $urandom, cur_mono,
           ($urandom_range(0, 2999) == 0));
    end
    idle(600);
    chk("frames_seen", (frames_seen >= 20), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
